// File: rtl/rr_pkg.sv
// Shared state encoding and default sizing for the round-robin grant sequencer.
package rr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        GRANT = 2'd2
    } rr_state_t;

    localparam int REQCNT_DEF   = 5;
    localparam int MAXBURST_DEF = 8;
    localparam int TIMEOUT_DEF  = 16;

endpackage

// File: rtl/rr_onehot_dec.sv
// Client index to one-hot decoder; an index past the last client decodes to all zeros.
module rr_onehot_dec
    import rr_pkg::*;
#(
    parameter int REQCNT   = REQCNT_DEF,
    parameter int REQWIDTH = $clog2(REQCNT)
) (
    input  logic [REQWIDTH-1:0] idx,
    input  logic                en,
    output logic [REQCNT-1:0]   onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < REQCNT; i++) begin
            onehot[i] = en && (idx == REQWIDTH'(i));
        end
    end

endmodule

// File: rtl/rr_grant_ctrl.sv
// Grant sequencer around an external round-robin arbiter: snapshot, one-cycle arbitration, held burst grant.
//
// state | meaning
// IDLE  | no grant; samples req_i and captures a snapshot when any client requests
// ARB   | snapshot presented with arb_val_o for exactly one cycle; arbiter index registered
// GRANT | one-hot grant held until last beat, full burst, request drop or idle timeout
module rr_grant_ctrl
    import rr_pkg::*;
#(
    parameter int REQCNT   = REQCNT_DEF,
    parameter int REQWIDTH = $clog2(REQCNT),
    parameter int MAXBURST = MAXBURST_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF,
    parameter int CNTW     = $clog2(MAXBURST + 1),
    parameter int TOW      = $clog2(TIMEOUT + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [REQCNT-1:0]   req_i,
    output logic [REQCNT-1:0]   arb_req_o,
    output logic                arb_val_o,
    input  logic [REQWIDTH-1:0] arb_num_i,
    output logic [REQCNT-1:0]   gnt_o,
    output logic [REQWIDTH-1:0] gnt_num_o,
    output logic                gnt_val_o,
    input  logic                beat_i,
    input  logic                last_i,
    output logic                timeout_o
);

    rr_state_t           state;
    logic [REQCNT-1:0]   snap;
    logic [REQWIDTH-1:0] gnt_num;
    logic [CNTW-1:0]     beat_cnt;
    logic [TOW-1:0]      to_cnt;

    logic [REQCNT-1:0]   arb_sel;
    logic [REQCNT-1:0]   gnt_oh;
    logic [CNTW-1:0]     beat_nxt;
    logic [TOW-1:0]      to_nxt;
    logic                in_grant;
    logic                arb_ok;
    logic                exit_last;
    logic                exit_burst;
    logic                exit_drop;
    logic                exit_to;
    logic                grant_exit;

    assign in_grant = (state == GRANT);

    // Decoding the arbiter index covers both the range check and the snapshot-bit check.
    rr_onehot_dec #(.REQCNT(REQCNT), .REQWIDTH(REQWIDTH)) u_arb_dec (
        .idx    (arb_num_i),
        .en     (1'b1),
        .onehot (arb_sel)
    );

    rr_onehot_dec #(.REQCNT(REQCNT), .REQWIDTH(REQWIDTH)) u_gnt_dec (
        .idx    (gnt_num),
        .en     (in_grant),
        .onehot (gnt_oh)
    );

    assign arb_ok     = |(snap & arb_sel);
    assign beat_nxt   = beat_cnt + 1'b1;
    assign to_nxt     = to_cnt + 1'b1;

    assign exit_last  = beat_i & last_i;
    assign exit_burst = beat_i & (beat_nxt == CNTW'(MAXBURST));
    assign exit_drop  = ~|(req_i & gnt_oh);
    assign exit_to    = ~beat_i & (to_nxt == TOW'(TIMEOUT));
    assign grant_exit = exit_last | exit_burst | exit_drop | exit_to;

    assign arb_val_o  = (state == ARB);
    assign arb_req_o  = arb_val_o ? snap : '0;
    assign gnt_o      = gnt_oh;
    assign gnt_val_o  = in_grant;
    assign gnt_num_o  = in_grant ? gnt_num : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            snap      <= '0;
            gnt_num   <= '0;
            beat_cnt  <= '0;
            to_cnt    <= '0;
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req_i) begin
                        snap  <= req_i;
                        state <= ARB;
                    end
                end
                ARB: begin
                    gnt_num <= arb_num_i;
                    state   <= arb_ok ? GRANT : IDLE;
                end
                GRANT: begin
                    if (grant_exit) begin
                        state     <= IDLE;
                        beat_cnt  <= '0;
                        to_cnt    <= '0;
                        // A request drop in the same cycle wins; the pulse marks a pure timeout only.
                        timeout_o <= exit_to & ~exit_drop;
                    end else if (beat_i) begin
                        beat_cnt <= beat_nxt;
                        to_cnt   <= '0;
                    end else begin
                        to_cnt <= to_nxt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Self-checking bench for rr_grant_ctrl: per-cycle expected output vectors queued with each stimulus step.
module tb_rr_grant_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] req;
    logic [4:0] arb_req;
    logic       arb_val;
    logic [2:0] arb_num;
    logic [4:0] gnt;
    logic [2:0] gnt_num;
    logic       gnt_val;
    logic       beat;
    logic       last;
    logic       timeout;

    logic [15:0] obs;
    logic [15:0] exp_q[$];
    int vectors;
    int miscompares;

    rr_grant_ctrl dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_i     (req),
        .arb_req_o (arb_req),
        .arb_val_o (arb_val),
        .arb_num_i (arb_num),
        .gnt_o     (gnt),
        .gnt_num_o (gnt_num),
        .gnt_val_o (gnt_val),
        .beat_i    (beat),
        .last_i    (last),
        .timeout_o (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {arb_val, arb_req, gnt_val, gnt, gnt_num, timeout};

    // Expected packed outputs: arbitration cycle, granted cycle, and the idle pulse cycle.
    function automatic logic [15:0] ev_arb(input logic [4:0] ar);
        return {1'b1, ar, 1'b0, 5'b00000, 3'b000, 1'b0};
    endfunction

    function automatic logic [15:0] ev_gnt(input logic [2:0] n);
        logic [4:0] oh;
        oh = 5'b00001 << n;
        return {1'b0, 5'b00000, 1'b1, oh, n, 1'b0};
    endfunction

    localparam logic [15:0] EV_IDLE = 16'h0000;
    localparam logic [15:0] EV_TO   = 16'h0001;

    task automatic test_reset();
        logic [15:0] e;
        rst = 1'b1; req = 5'b11111; arb_num = 3'd0; beat = 1'b1; last = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                rst = 1'b0; req = '0; beat = 1'b0; last = 1'b0;
            end
            exp_q.push_back(EV_IDLE);
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL reset k=%0d got=%h exp=%h", k, obs, e);
            end
        end
    endtask

    task automatic test_timeout();
        logic [15:0] e;
        for (int k = 0; k < 19; k++) begin
            req = (k < 18) ? 5'b00100 : 5'b00000;
            arb_num = 3'd2; beat = 1'b0; last = 1'b0;
            if (k == 0)       exp_q.push_back(ev_arb(5'b00100));
            else if (k <= 16) exp_q.push_back(ev_gnt(3'd2));
            else if (k == 17) exp_q.push_back(EV_TO);
            else              exp_q.push_back(EV_IDLE);
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL timeout k=%0d got=%h exp=%h", k, obs, e);
            end
        end
    endtask

    task automatic test_burst();
        logic [15:0] e;
        for (int k = 0; k < 14; k++) begin
            req = (k < 12) ? 5'b00010 : 5'b00000;
            arb_num = 3'd1; beat = (k < 12); last = 1'b0;
            if (k == 0 || k == 10)        exp_q.push_back(ev_arb(5'b00010));
            else if (k <= 8 || k == 11)   exp_q.push_back(ev_gnt(3'd1));
            else                          exp_q.push_back(EV_IDLE);
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL burst k=%0d got=%h exp=%h", k, obs, e);
            end
        end
    endtask

    task automatic test_last();
        logic [15:0] e;
        for (int k = 0; k < 7; k++) begin
            req = (k >= 6) ? 5'b00000 : ((k >= 3) ? 5'b01010 : 5'b01000);
            arb_num = 3'd3;
            beat = (k >= 3 && k <= 5);
            last = (k == 2 || k == 5);
            if (k == 0)      exp_q.push_back(ev_arb(5'b01000));
            else if (k <= 4) exp_q.push_back(ev_gnt(3'd3));
            else             exp_q.push_back(EV_IDLE);
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL last k=%0d got=%h exp=%h", k, obs, e);
            end
        end
    endtask

    task automatic test_drop();
        logic [15:0] e;
        for (int k = 0; k < 4; k++) begin
            req = (k < 2) ? 5'b00001 : 5'b00000;
            arb_num = 3'd0; beat = (k == 2); last = 1'b0;
            if (k == 0)      exp_q.push_back(ev_arb(5'b00001));
            else if (k == 1) exp_q.push_back(ev_gnt(3'd0));
            else             exp_q.push_back(EV_IDLE);
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL drop_beat k=%0d got=%h exp=%h", k, obs, e);
            end
        end
        // Request drop coinciding with the timeout edge: single exit, no pulse.
        for (int k = 0; k < 19; k++) begin
            req = (k < 17) ? 5'b10000 : 5'b00000;
            arb_num = 3'd4; beat = 1'b0; last = 1'b0;
            if (k == 0)       exp_q.push_back(ev_arb(5'b10000));
            else if (k <= 16) exp_q.push_back(ev_gnt(3'd4));
            else              exp_q.push_back(EV_IDLE);
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL drop_timeout k=%0d got=%h exp=%h", k, obs, e);
            end
        end
    endtask

    task automatic test_bad_index();
        logic [15:0] e;
        for (int k = 0; k < 7; k++) begin
            req = (k < 6) ? 5'b00101 : 5'b00000;
            case (k)
                3:       arb_num = 3'd1;
                5:       arb_num = 3'd5;
                default: arb_num = 3'd6;
            endcase
            beat = 1'b1; last = 1'b1;
            if (k == 0 || k == 2 || k == 4) exp_q.push_back(ev_arb(5'b00101));
            else                            exp_q.push_back(EV_IDLE);
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL bad_index k=%0d got=%h exp=%h", k, obs, e);
            end
        end
        beat = 1'b0; last = 1'b0;
    endtask

    task automatic test_reset_mid_grant();
        logic [15:0] e;
        for (int k = 0; k < 16; k++) begin
            rst = (k == 4);
            req = (k < 15) ? 5'b00100 : 5'b00000;
            arb_num = 3'd2;
            beat = (k == 2) || (k >= 7 && k <= 14);
            last = 1'b0;
            if (k == 0 || k == 5)                exp_q.push_back(ev_arb(5'b00100));
            else if (k <= 3 || (k >= 6 && k <= 13)) exp_q.push_back(ev_gnt(3'd2));
            else                                 exp_q.push_back(EV_IDLE);
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL reset_mid k=%0d got=%h exp=%h", k, obs, e);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_timeout();
        test_burst();
        test_last();
        test_drop();
        test_bad_index();
        test_reset_mid_grant();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
